// File: rtl/twofish_gf_matmul_seq.sv
// Sequential GF(2^8) matrix-vector multiplier shared by the Twofish MDS (4x4, 0x169)
// and Reed-Solomon (4x8, 0x14D) transforms; BPC input columns are folded in per cycle.
module twofish_gf_matmul_seq #(
    parameter int BPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
        $error("twofish_gf_matmul_seq: BPC must be 1, 2 or 4");
    end

    // Row-major constants; element [row][col] is the coefficient for out byte row, in byte col.
    localparam logic [0:3][0:3][7:0] MDS_M = {
        32'h01EF5B5B, 32'h5BEFEF01, 32'hEF5B01EF, 32'hEF01EF5B
    };
    localparam logic [0:3][0:7][7:0] RS_M = {
        64'h01A4_5587_5A58_DB9E, 64'hA456_82F3_1EC6_68E5,
        64'h02A1_FCC1_47AE_3D19, 64'hA455_875A_58DB_9E03
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [63:0]     data_q;
    logic            mode_q;
    logic [3:0]      cnt;
    logic [3:0][7:0] acc, acc_nxt;
    logic            last;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic rs);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ (rs ? 8'h4D : 8'h69)) : (x << 1);
        end
        return p;
    endfunction

    // Product of one input column with all four matrix rows.
    function automatic logic [3:0][7:0] col_term(input logic rs, input logic [63:0] d,
                                                 input logic [2:0] col);
        logic [3:0][7:0] t;
        logic [7:0]      b;
        b = d[{col, 3'b000} +: 8];
        for (int r = 0; r < 4; r++)
            t[r] = gf_mul(rs ? RS_M[r][col] : MDS_M[r][col[1:0]], b, rs);
        return t;
    endfunction

    always_comb begin
        acc_nxt = acc;
        for (int k = 0; k < BPC; k++)
            acc_nxt = acc_nxt ^ col_term(mode_q, data_q, cnt[2:0] + 3'(k));
    end

    assign last = (cnt + 4'(BPC)) >= (mode_q ? 4'd8 : 4'd4);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            mode_q <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    data_q <= in_data;
                    mode_q <= mode;
                    acc    <= '0;
                    cnt    <= '0;
                end
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 4'(BPC);
                end
                default: ;
            endcase
        end
    end

    assign out_data = acc;

endmodule

// File: tb/tb_twofish_gf_matmul_seq.sv
// Directed + randomised check of twofish_gf_matmul_seq, run side by side for BPC = 1, 2, 4.
module tb_twofish_gf_matmul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] in_data = '0;
    logic        rdy [3];
    logic        ov  [3];
    logic [31:0] od  [3];

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] MDS_R [4] = '{32'h01EF5B5B, 32'h5BEFEF01, 32'hEF5B01EF, 32'hEF01EF5B};
    localparam logic [63:0] RS_R  [4] = '{64'h01A4_5587_5A58_DB9E, 64'hA456_82F3_1EC6_68E5,
                                          64'h02A1_FCC1_47AE_3D19, 64'hA455_875A_58DB_9E03};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        twofish_gf_matmul_seq #(.BPC(1 << g)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[g]), .mode(mode),
            .in_data(in_data), .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Carry-less product followed by explicit reduction.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input bit rs);
        logic [15:0] p;
        logic [15:0] poly;
        p = '0;
        poly = rs ? 16'h014D : 16'h0169;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (poly << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] ref_model(input bit rs, input logic [63:0] d);
        logic [31:0] res;
        logic [7:0]  c;
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < (rs ? 8 : 4); j++) begin
                c = rs ? RS_R[r][63 - 8*j -: 8] : MDS_R[r][31 - 8*j -: 8];
                res[8*r +: 8] = res[8*r +: 8] ^ ref_mul(c, d[8*j +: 8], rs);
            end
        return res;
    endfunction

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (!(rdy[0] && rdy[1] && rdy[2]) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "/idle"}, 32'(rdy[0] && rdy[1] && rdy[2]), 32'd1);
    endtask

    task automatic run(input bit m, input logic [63:0] d, input logic [31:0] exp,
                       input bit stall, input string tag);
        bit          seen [3];
        logic [31:0] val  [3];
        int          lat  [3];
        bit          stable;
        bit          fin;
        int          cyc;
        wait_idle(tag);
        mode = m; in_data = d; in_valid = 1'b1;
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        // Perturb inputs after acceptance; the latched copy must be used.
        in_valid = 1'b0; in_data = ~d; mode = ~m;
        for (int g = 0; g < 3; g++) begin seen[g] = 0; val[g] = '0; lat[g] = -1; end
        stable = 1; fin = 0; cyc = 0;
        for (int t = 0; t < 300 && !fin; t++) begin
            @(posedge clk); #1;
            cyc++;
            fin = 1;
            for (int g = 0; g < 3; g++) begin
                if (ov[g]) begin
                    if (!seen[g]) begin seen[g] = 1; lat[g] = cyc; val[g] = od[g]; end
                    else if (od[g] !== val[g]) stable = 0;
                end
                if (!(seen[g] && rdy[g])) fin = 0;
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        out_ready = 1'b1;
        chk({tag, "/complete"}, 32'(fin), 32'd1);
        chk({tag, "/stable"}, 32'(stable), 32'd1);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s/bpc%0d/data", tag, 1 << g), val[g], exp);
            chk($sformatf("%s/bpc%0d/lat", tag, 1 << g), 32'(lat[g]), 32'((m ? 8 : 4) >> g));
        end
    endtask

    task automatic backpressure();
        int t;
        int bad;
        wait_idle("bp");
        mode = 1'b0; in_data = 64'h01; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (!(ov[0] && ov[1] && ov[2]) && t < 20) begin @(posedge clk); #1; t++; end
        chk("bp/valid", 32'(ov[0] && ov[1] && ov[2]), 32'd1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data = {$urandom, $urandom};
            mode = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++)
                if (od[g] !== 32'hEFEF5B01 || rdy[g] !== 1'b0 || ov[g] !== 1'b1) bad++;
        end
        chk("bp/hold", 32'(bad), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("bp/bpc%0d/ready_after", 1 << g), 32'(rdy[g]), 32'd1);
            chk($sformatf("bp/bpc%0d/valid_after", 1 << g), 32'(ov[g]), 32'd0);
        end
    endtask

    task automatic reset_mid();
        int any_ov;
        wait_idle("rstmid");
        mode = 1'b1; in_data = 64'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        // Second BUSY cycle: reset plus a competing request that must be refused.
        rst = 1'b1; in_valid = 1'b1; mode = 1'b0; in_data = 64'h01;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rstmid/bpc%0d/ready", 1 << g), 32'(rdy[g]), 32'd1);
            chk($sformatf("rstmid/bpc%0d/valid", 1 << g), 32'(ov[g]), 32'd0);
        end
        any_ov = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++) if (ov[g] || !rdy[g]) any_ov++;
        end
        chk("rstmid/quiet", 32'(any_ov), 32'd0);
        run(1'b0, 64'h01, 32'hEFEF5B01, 1'b0, "rstmid/next");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset/bpc%0d/ready", 1 << g), 32'(rdy[g]), 32'd1);
            chk($sformatf("reset/bpc%0d/valid", 1 << g), 32'(ov[g]), 32'd0);
            chk($sformatf("reset/bpc%0d/data", 1 << g), od[g], 32'h0);
        end
        rst = 1'b0;

        run(1'b0, 64'h0000_0000_0000_0001, 32'hEFEF5B01, 1'b0, "mds_b0");
        run(1'b0, 64'h0000_0000_0000_0200, 32'h02B6B7B7, 1'b0, "mds_b1");
        run(1'b0, 64'h0000_0000_0000_0201, 32'hED59ECB6, 1'b0, "mds_lin");
        run(1'b1, 64'h0000_0000_0000_0001, 32'hA402A401, 1'b0, "rs_b0");
        run(1'b1, 64'h0100_0000_0000_0000, 32'h0319E59E, 1'b0, "rs_b7");
        run(1'b0, 64'hFFFF_FFFF_0000_0001, 32'hEFEF5B01, 1'b0, "mds_hi_b0");
        run(1'b0, 64'hFFFF_FFFF_0000_0201, 32'hED59ECB6, 1'b0, "mds_hi_lin");

        backpressure();
        reset_mid();

        for (int i = 0; i < 300; i++) begin
            bit          m;
            logic [63:0] d;
            m = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            run(m, d, ref_model(m, d), 1'b1, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
